// File: rtl/lmc_program_loader.sv
// Program RAM writer for the LMC: receives a framed image (length, bytes, checksum),
// writes it into RAM, reads it back to verify, and holds the CPU until it is good.
module lmc_program_loader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  timer555,
  input  logic                  reset_count_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int LW    = DATA_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CSUM   = 3'd4,
    ST_VERIFY = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  state_t                state_r;
  logic                  in_ready_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  cpu_hold_r;
  logic                  done_r;
  logic                  error_r;
  logic [CW-1:0]         n_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] sum_r;
  logic [DATA_WIDTH-1:0] csum_r;
  logic [DATA_WIDTH-1:0] rsum_r;

  logic          xfer_s;
  logic [CW-1:0] count_inc_s;

  assign xfer_s      = in_valid & in_ready_r;
  assign count_inc_s = count_r + CW'(1);

  // Load sequencer: stream intake, RAM write strobes, read-back verify and status flags.
  always_ff @(posedge timer555 or negedge reset_count_n) begin
    if (!reset_count_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      n_r         <= '0;
      count_r     <= '0;
      sum_r       <= '0;
      csum_r      <= '0;
      rsum_r      <= '0;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r    <= ST_LEN;
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            sum_r      <= '0;
            count_r    <= '0;
            mem_addr_r <= '0;
          end
        end
        ST_LEN: begin
          if (xfer_s) begin
            // A zero length byte stands for a full RAM image.
            if (LW'(in_data) > DEPTH_L) begin
              state_r    <= ST_ERROR;
              in_ready_r <= 1'b0;
              error_r    <= 1'b1;
            end else begin
              n_r     <= (in_data == '0) ? DEPTH_C : CW'(in_data);
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            mem_wdata_r <= in_data;
            sum_r       <= sum_r + in_data;
            mem_we_r    <= 1'b1;
            in_ready_r  <= 1'b0;
            state_r     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          count_r    <= count_inc_s;
          in_ready_r <= 1'b1;
          if (count_inc_s == n_r) begin
            mem_addr_r <= '0;
            state_r    <= ST_CSUM;
          end else begin
            mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
            state_r    <= ST_DATA;
          end
        end
        ST_CSUM: begin
          if (xfer_s) begin
            csum_r     <= in_data;
            in_ready_r <= 1'b0;
            if (in_data != sum_r) begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
            end else begin
              rsum_r  <= '0;
              count_r <= '0;
              state_r <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          // N read-back samples, then one cycle to compare the accumulated sum.
          if (count_r != n_r) begin
            rsum_r     <= rsum_r + mem_rdata;
            mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
            count_r    <= count_inc_s;
          end else begin
            mem_addr_r <= '0;
            if (rsum_r == csum_r) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_ERROR;
          in_ready_r <= 1'b0;
          cpu_hold_r <= 1'b1;
          error_r    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_lmc_program_loader.sv
// Bench for lmc_program_loader: RAM model with optional read corruption, a table of
// directed frames, randomized frames against a frame-level model, and a reset corner.
module tb_lmc_program_loader;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          timer555 = 1'b0;
  logic          reset_count_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = 8'h00;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  lmc_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .timer555(timer555), .reset_count_n(reset_count_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 timer555 = ~timer555;

  // RAM model: synchronous write, asynchronous read, optional corruption of address 2.
  logic [DW-1:0] ram [DEPTH];
  bit            corrupt = 1'b0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  always @(posedge timer555) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end
  assign mem_rdata = (corrupt && mem_addr == 2'd2) ? ~ram[mem_addr] : ram[mem_addr];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Frame-level reference: number of RAM writes and whether the load ends in done.
  function automatic void model(input logic [7:0] len, input logic [3:0][7:0] d,
                                input logic [7:0] cs, input bit cor,
                                output int nw, output bit ok);
    int s, r;
    s = 0; r = 0;
    if (len > 8'd4) begin
      nw = 0; ok = 1'b0;
      return;
    end
    nw = (len == 8'd0) ? 4 : int'(len);
    for (int i = 0; i < nw; i++) begin
      s = (s + int'(d[i])) % 256;
      r = (r + ((cor && i == 2) ? 255 - int'(d[i]) : int'(d[i]))) % 256;
    end
    ok = (s == int'(cs)) && (r == int'(cs));
  endfunction

  // Drives one framed load; returns clocks from the start edge until done/error shows.
  task automatic run_load(input logic [7:0] len, input logic [3:0][7:0] d, input logic [7:0] cs,
                          input int pct, output int cycles, output int viol);
    logic [7:0] q [$];
    int idx, e, nw;
    q.push_back(len);
    if (len <= 8'd4) begin
      nw = (len == 8'd0) ? 4 : int'(len);
      for (int i = 0; i < nw; i++) q.push_back(d[i]);
      q.push_back(cs);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    viol = 0; idx = 0; cycles = -1;
    @(negedge timer555);
    start = 1'b1; in_valid = 1'b0;
    @(posedge timer555);
    e = 1;
    while (e < 200) begin
      @(negedge timer555);
      start = 1'b0;
      if (done || error) begin
        cycles = e;
        break;
      end
      if (!cpu_hold) viol++;
      if (mem_we && in_ready) viol++;
      if (idx == q.size() && (in_ready || mem_we)) viol++;
      in_valid = (idx < q.size()) && ($urandom_range(99) < pct);
      if (idx < q.size()) in_data = q[idx];
      if (in_valid && in_ready) idx++;
      @(posedge timer555);
      e++;
    end
    in_valid = 1'b0;
  endtask

  task automatic apply(input string nm, input logic [7:0] len, input logic [3:0][7:0] d,
                       input logic [7:0] cs, input bit cor, input int pct,
                       input bit exp_done, input bit exp_err, input int exp_cycles,
                       input int exp_writes);
    int cyc, viol, bad;
    corrupt = cor;
    run_load(len, d, cs, pct, cyc, viol);
    if (exp_cycles >= 0) check({nm, ".cycles"}, cyc, exp_cycles);
    else check({nm, ".finished"}, int'(cyc > 0), 1);
    check({nm, ".done"}, int'(done), int'(exp_done));
    check({nm, ".error"}, int'(error), int'(exp_err));
    check({nm, ".cpu_hold"}, int'(cpu_hold), int'(!exp_done));
    check({nm, ".protocol"}, viol, 0);
    check({nm, ".writes"}, wr_addr_q.size(), exp_writes);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (int'(wr_addr_q[i]) != i || wr_data_q[i] != d[i]) bad++;
    check({nm, ".wdata"}, bad, 0);
    corrupt = 1'b0;
  endtask

  typedef struct {
    string           name;
    logic [7:0]      len;
    logic [3:0][7:0] d;
    logic [7:0]      cs;
    bit              cor;
    bit              exp_done;
    bit              exp_err;
    int              exp_cycles;
    int              exp_writes;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [3:0][7:0] rd;
    logic [7:0] rlen, rcs;
    bit rcor, rok;
    int rnw, s;

    vecs[0] = '{"load4",    8'h04, {8'h44, 8'h33, 8'h22, 8'h11}, 8'hAA, 1'b0, 1'b1, 1'b0, 16, 4};
    vecs[1] = '{"load2",    8'h02, {8'h00, 8'h00, 8'h07, 8'h05}, 8'h0C, 1'b0, 1'b1, 1'b0, 10, 2};
    vecs[2] = '{"badcsum",  8'h02, {8'h00, 8'h00, 8'h07, 8'h05}, 8'h0E, 1'b0, 1'b0, 1'b1, 7,  2};
    vecs[3] = '{"badlen",   8'h05, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 1'b0, 1'b1, 2,  0};
    vecs[4] = '{"len0",     8'h00, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 8'hEA, 1'b0, 1'b1, 1'b0, 16, 4};
    vecs[5] = '{"len0corr", 8'h00, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 8'hEA, 1'b1, 1'b0, 1'b1, 16, 4};

    repeat (2) @(negedge timer555);
    check("reset.outputs", int'({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}), 0);
    reset_count_n = 1'b1;

    for (int i = 0; i < 6; i++)
      apply(vecs[i].name, vecs[i].len, vecs[i].d, vecs[i].cs, vecs[i].cor, 100,
            vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_cycles, vecs[i].exp_writes);

    apply("load4.gappy", vecs[0].len, vecs[0].d, vecs[0].cs, 1'b0, 50, 1'b1, 1'b0, -1, 4);

    for (int k = 0; k < 20; k++) begin
      rlen = 8'($urandom_range(5));
      rd   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      s = 0;
      for (int i = 0; i < ((rlen == 8'd0) ? 4 : int'(rlen)) && i < 4; i++) s = (s + int'(rd[i])) % 256;
      rcs  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(s);
      rcor = 1'($urandom_range(1));
      model(rlen, rd, rcs, rcor, rnw, rok);
      apply($sformatf("rand%0d", k), rlen, rd, rcs, rcor, int'($urandom_range(100, 30)),
            rok, !rok, -1, rnw);
    end

    // Reset in the middle of DATA, after the first word has been written.
    @(negedge timer555);
    start = 1'b1; in_valid = 1'b0;
    @(negedge timer555);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h04;
    @(negedge timer555);
    in_data = 8'h11;
    @(negedge timer555);
    in_valid = 1'b0;
    @(negedge timer555);
    check("midload.in_ready", int'(in_ready), 1);
    @(posedge timer555);
    #2 reset_count_n = 1'b0;
    #1 check("midload.reset_outputs",
             int'({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}), 0);
    check("midload.ram0", int'(ram[0]), 8'h11);
    @(negedge timer555);
    reset_count_n = 1'b1;
    apply("after_reset", vecs[0].len, vecs[0].d, vecs[0].cs, 1'b0, 100, 1'b1, 1'b0, 16, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
